systolic_tile_sched: RTL and testbench

Job-level tile scheduler that sits above `systolic_controll` and drives its `tpu_start`/`tpu_done` handshake. It accepts one GEMM job descriptor (M, N and K tile counts) and walks the tile loop nest. For each tile it issues one start pulse, along with the tile coordinates, SRAM base addresses and an accumulate flag. It reports job completion or error to the host side.

---
 rtl/systolic_tile_sched.sv | 251 +++++++++++++++++++++++++
 tb/tb_systolic_tile_sched.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_tile_sched.sv
// -----------------------------------------------------------------------------
// systolic_tile_sched
// Job-level tile scheduler for the systolic controller. Accepts one GEMM job
// (M/N/K tile counts), walks the tile loop nest (k innermost, then n, then m),
// and issues one tpu_start per tile along with the tile coordinates, the SRAM
// base addresses and an accumulate flag. Reports job completion or error.
//
// Ports:
//   clk, srstn                    clock, synchronous active-low reset
//   job_valid / job_ready         job descriptor handshake (ready only in IDLE)
//   job_m/n/k_tiles               tile counts, sampled at the handshake
//   tpu_start / tpu_done          per-tile handshake with the systolic controller
//   tile_m/n/k                    current tile indices
//   a_base / b_base / c_base      SRAM base addresses of the current tile
//   accum_en                      0 on the first k step (overwrite C), else 1
//   busy                          high whenever not IDLE
//   job_done / job_err            one-cycle completion pulse and its error flag
//
// Optional build macro: TILE_SCHED_TIMEOUT_EN enables a WAIT_DONE watchdog of
// TIMEOUT_CYCLES cycles that aborts the job with job_err set.
// -----------------------------------------------------------------------------
module systolic_tile_sched #(
    parameter int unsigned TILE_DIM_W     = 6,
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned A_TILE_WORDS   = 8,
    parameter int unsigned B_TILE_WORDS   = 8,
    parameter int unsigned C_TILE_WORDS   = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [TILE_DIM_W-1:0] job_m_tiles,
    input  logic [TILE_DIM_W-1:0] job_n_tiles,
    input  logic [TILE_DIM_W-1:0] job_k_tiles,
    output logic                  tpu_start,
    input  logic                  tpu_done,
    output logic [TILE_DIM_W-1:0] tile_m,
    output logic [TILE_DIM_W-1:0] tile_n,
    output logic [TILE_DIM_W-1:0] tile_k,
    output logic [ADDR_W-1:0]     a_base,
    output logic [ADDR_W-1:0]     b_base,
    output logic [ADDR_W-1:0]     c_base,
    output logic                  accum_en,
    output logic                  busy,
    output logic                  job_done,
    output logic                  job_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_ADVANCE = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    localparam logic [ADDR_W-1:0]     A_STEP = ADDR_W'(A_TILE_WORDS);
    localparam logic [ADDR_W-1:0]     B_STEP = ADDR_W'(B_TILE_WORDS);
    localparam logic [ADDR_W-1:0]     C_STEP = ADDR_W'(C_TILE_WORDS);
    localparam logic [TILE_DIM_W-1:0] ONE    = TILE_DIM_W'(1);

    logic [2:0]            state, state_nx;
    logic [TILE_DIM_W-1:0] mt, nt, kt, mt_nx, nt_nx, kt_nx;
    logic [TILE_DIM_W-1:0] m_nx, n_nx, k_nx;
    logic [ADDR_W-1:0]     a_nx, b_nx, c_nx;
    // a_row = m*Kt*A (A base of k=0 in the current m row); b_col = n*B;
    // nt_b = Nt*B (B stride per k step)
    logic [ADDR_W-1:0]     a_row, a_row_nx, b_col, b_col_nx, nt_b, nt_b_nx;
    logic                  err_flag, err_flag_nx;
    logic                  accum_nx, start_nx, done_nx, err_nx, ready_nx, busy_nx;
    logic                  k_last_c, n_last_c, m_last_c;

`ifdef TILE_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] wd_cnt, wd_cnt_nx;
`else
    logic timeout_unused_c;
    assign timeout_unused_c = (TIMEOUT_CYCLES == 0);
`endif

    assign k_last_c = (tile_k == kt - ONE);
    assign n_last_c = (tile_n == nt - ONE);
    assign m_last_c = (tile_m == mt - ONE);

    // Next-state, next-counter and next-output logic
    always_comb begin
        state_nx    = state;
        mt_nx       = mt;
        nt_nx       = nt;
        kt_nx       = kt;
        m_nx        = tile_m;
        n_nx        = tile_n;
        k_nx        = tile_k;
        a_nx        = a_base;
        b_nx        = b_base;
        c_nx        = c_base;
        a_row_nx    = a_row;
        b_col_nx    = b_col;
        nt_b_nx     = nt_b;
        err_flag_nx = err_flag;
        accum_nx    = accum_en;
`ifdef TILE_SCHED_TIMEOUT_EN
        wd_cnt_nx   = wd_cnt;
`endif

        case (state)
            S_IDLE: begin
                if (job_valid && job_ready) begin
                    mt_nx    = job_m_tiles;
                    nt_nx    = job_n_tiles;
                    kt_nx    = job_k_tiles;
                    m_nx     = '0;
                    n_nx     = '0;
                    k_nx     = '0;
                    a_nx     = '0;
                    b_nx     = '0;
                    c_nx     = '0;
                    a_row_nx = '0;
                    b_col_nx = '0;
                    nt_b_nx  = ADDR_W'(job_n_tiles) * B_STEP;
                    accum_nx = 1'b0;
                    // An empty job passes once through ADVANCE so that its
                    // done lands two cycles after the handshake.
                    if (job_m_tiles == '0 || job_n_tiles == '0 || job_k_tiles == '0) begin
                        err_flag_nx = 1'b1;
                        state_nx    = S_ADVANCE;
                    end else begin
                        err_flag_nx = 1'b0;
                        state_nx    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_nx = S_WAIT;
`ifdef TILE_SCHED_TIMEOUT_EN
                wd_cnt_nx = '0;
`endif
            end
            S_WAIT: begin
                if (tpu_done) begin
                    state_nx = S_ADVANCE;
                end
`ifdef TILE_SCHED_TIMEOUT_EN
                else if (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nx    = S_FINISH;
                    err_flag_nx = 1'b1;
                end else begin
                    wd_cnt_nx = wd_cnt + TO_W'(1);
                end
`endif
            end
            S_ADVANCE: begin
                if (err_flag || (k_last_c && n_last_c && m_last_c)) begin
                    state_nx = S_FINISH;
                end else begin
                    state_nx = S_ISSUE;
                    if (!k_last_c) begin
                        k_nx = tile_k + ONE;
                        a_nx = a_base + A_STEP;
                        b_nx = b_base + nt_b;
                    end else begin
                        // C tiles are visited linearly: one step per k wrap
                        k_nx = '0;
                        c_nx = c_base + C_STEP;
                        if (!n_last_c) begin
                            n_nx     = tile_n + ONE;
                            a_nx     = a_row;
                            b_col_nx = b_col + B_STEP;
                            b_nx     = b_col + B_STEP;
                        end else begin
                            // Next m row starts right after the last A tile
                            n_nx     = '0;
                            m_nx     = tile_m + ONE;
                            b_col_nx = '0;
                            b_nx     = '0;
                            a_nx     = a_base + A_STEP;
                            a_row_nx = a_base + A_STEP;
                        end
                    end
                    accum_nx = (k_nx != '0);
                end
            end
            S_FINISH: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        start_nx = (state_nx == S_ISSUE);
        done_nx  = (state_nx == S_FINISH);
        err_nx   = (state_nx == S_FINISH) && err_flag_nx;
        ready_nx = (state_nx == S_IDLE);
        busy_nx  = (state_nx != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state     <= S_IDLE;
            mt        <= '0;
            nt        <= '0;
            kt        <= '0;
            tile_m    <= '0;
            tile_n    <= '0;
            tile_k    <= '0;
            a_base    <= '0;
            b_base    <= '0;
            c_base    <= '0;
            a_row     <= '0;
            b_col     <= '0;
            nt_b      <= '0;
            err_flag  <= 1'b0;
            accum_en  <= 1'b0;
            tpu_start <= 1'b0;
            job_done  <= 1'b0;
            job_err   <= 1'b0;
            job_ready <= 1'b1;
            busy      <= 1'b0;
`ifdef TILE_SCHED_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
        end else begin
            state     <= state_nx;
            mt        <= mt_nx;
            nt        <= nt_nx;
            kt        <= kt_nx;
            tile_m    <= m_nx;
            tile_n    <= n_nx;
            tile_k    <= k_nx;
            a_base    <= a_nx;
            b_base    <= b_nx;
            c_base    <= c_nx;
            a_row     <= a_row_nx;
            b_col     <= b_col_nx;
            nt_b      <= nt_b_nx;
            err_flag  <= err_flag_nx;
            accum_en  <= accum_nx;
            tpu_start <= start_nx;
            job_done  <= done_nx;
            job_err   <= err_nx;
            job_ready <= ready_nx;
            busy      <= busy_nx;
`ifdef TILE_SCHED_TIMEOUT_EN
            wd_cnt    <= wd_cnt_nx;
`endif
        end
    end

endmodule

// File: tb/tb_systolic_tile_sched.sv
// -----------------------------------------------------------------------------
// tb_systolic_tile_sched
// Directed bench for systolic_tile_sched: single-tile job, multi-tile loop
// order and base addresses, empty jobs, spurious tpu_done pulses, mid-job
// reset, address wrap at large tile counts and (with TILE_SCHED_TIMEOUT_EN)
// the WAIT_DONE watchdog.
// -----------------------------------------------------------------------------
module tb_systolic_tile_sched;

    localparam int unsigned TDW = 6;
    localparam int unsigned AW  = 10;
    localparam int unsigned WA  = 8;
    localparam int unsigned WB  = 8;
    localparam int unsigned WC  = 8;
`ifdef TILE_SCHED_TIMEOUT_EN
    localparam int unsigned TO  = 16;
`else
    localparam int unsigned TO  = 1023;
`endif

    logic           clk = 1'b0;
    logic           srstn = 1'b0;
    logic           job_valid = 1'b0;
    logic           job_ready;
    logic [TDW-1:0] job_m_tiles = '0;
    logic [TDW-1:0] job_n_tiles = '0;
    logic [TDW-1:0] job_k_tiles = '0;
    logic           tpu_start;
    logic           tpu_done = 1'b0;
    logic [TDW-1:0] tile_m, tile_n, tile_k;
    logic [AW-1:0]  a_base, b_base, c_base;
    logic           accum_en, busy, job_done, job_err;

    int n_vec  = 0;
    int n_miss = 0;

    systolic_tile_sched #(
        .TILE_DIM_W     (TDW),
        .ADDR_W         (AW),
        .A_TILE_WORDS   (WA),
        .B_TILE_WORDS   (WB),
        .C_TILE_WORDS   (WC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .srstn       (srstn),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_m_tiles (job_m_tiles),
        .job_n_tiles (job_n_tiles),
        .job_k_tiles (job_k_tiles),
        .tpu_start   (tpu_start),
        .tpu_done    (tpu_done),
        .tile_m      (tile_m),
        .tile_n      (tile_n),
        .tile_k      (tile_k),
        .a_base      (a_base),
        .b_base      (b_base),
        .c_base      (c_base),
        .accum_en    (accum_en),
        .busy        (busy),
        .job_done    (job_done),
        .job_err     (job_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, job_ready, 1);
        check_val({tag, "_busy"},  busy, 0);
        check_val({tag, "_start"}, tpu_start, 0);
        check_val({tag, "_done"},  job_done, 0);
        check_val({tag, "_err"},   job_err, 0);
        check_val({tag, "_tm"},    tile_m, 0);
        check_val({tag, "_tn"},    tile_n, 0);
        check_val({tag, "_tk"},    tile_k, 0);
        check_val({tag, "_a"},     a_base, 0);
        check_val({tag, "_b"},     b_base, 0);
        check_val({tag, "_c"},     c_base, 0);
        check_val({tag, "_acc"},   accum_en, 0);
    endtask

    // Run one job; tpu_done is returned dly cycles after each start. With
    // noise set, extra tpu_done pulses land in IDLE, ISSUE and ADVANCE.
    task automatic run_job(input int mt, input int nt, input int kt, input int dly, input bit noise);
        bit last;
        if (noise) begin
            tpu_done = 1'b1;
            tick;
            tpu_done = 1'b0;
            check_val("idle_noise_busy", busy, 0);
            check_val("idle_noise_start", tpu_start, 0);
        end
        check_val("hs_ready", job_ready, 1);
        job_valid   = 1'b1;
        job_m_tiles = TDW'(mt);
        job_n_tiles = TDW'(nt);
        job_k_tiles = TDW'(kt);
        tick;
        // Fields change after the handshake; must have no effect
        job_valid   = 1'b0;
        job_m_tiles = '1;
        job_n_tiles = '1;
        job_k_tiles = '1;
        check_val("ready_drop", job_ready, 0);
        check_val("busy_set", busy, 1);
        if (mt == 0 || nt == 0 || kt == 0) begin
            check_val("zd_start_t1", tpu_start, 0);
            tick;
            check_val("zd_done", job_done, 1);
            check_val("zd_err", job_err, 1);
            check_val("zd_start_t2", tpu_start, 0);
            tick;
            check_val("zd_ready", job_ready, 1);
            check_val("zd_done_clr", job_done, 0);
            check_val("zd_start_t3", tpu_start, 0);
            return;
        end
        for (int m = 0; m < mt; m++) begin
            for (int n = 0; n < nt; n++) begin
                for (int k = 0; k < kt; k++) begin
                    last = (m == mt - 1) && (n == nt - 1) && (k == kt - 1);
                    check_val("start", tpu_start, 1);
                    check_val("tile_m", tile_m, m);
                    check_val("tile_n", tile_n, n);
                    check_val("tile_k", tile_k, k);
                    check_val("a_base", a_base, ((m * kt + k) * WA) % 1024);
                    check_val("b_base", b_base, ((k * nt + n) * WB) % 1024);
                    check_val("c_base", c_base, ((m * nt + n) * WC) % 1024);
                    check_val("accum_en", accum_en, (k != 0));
                    tpu_done = noise;
                    tick;
                    tpu_done = 1'b0;
                    check_val("wait_start", tpu_start, 0);
                    repeat (dly - 1) tick;
                    tpu_done = 1'b1;
                    tick;
                    tpu_done = noise;
                    check_val("adv_start", tpu_start, 0);
                    check_val("adv_tile_k", tile_k, k);
                    check_val("adv_c_base", c_base, ((m * nt + n) * WC) % 1024);
                    check_val("adv_done", job_done, 0);
                    tick;
                    tpu_done = 1'b0;
                    if (last) begin
                        check_val("end_done", job_done, 1);
                        check_val("end_err", job_err, 0);
                        check_val("end_start", tpu_start, 0);
                    end else begin
                        check_val("mid_done", job_done, 0);
                    end
                end
            end
        end
        tick;
        check_val("post_ready", job_ready, 1);
        check_val("post_done", job_done, 0);
        check_val("post_busy", busy, 0);
        check_val("post_start", tpu_start, 0);
    endtask

    initial begin
        int starts;
        int done_seen;

        // Reset state
        tick;
        tick;
        check_reset_outputs("rst");
        srstn = 1'b1;
        tick;
        check_reset_outputs("rst_rel");

        run_job(1, 1, 1, 5, 1'b0);
        run_job(2, 2, 2, 2, 1'b0);
        run_job(0, 3, 3, 1, 1'b0);
        run_job(4, 4, 0, 1, 1'b0);
        run_job(2, 2, 2, 3, 1'b1);
        run_job(2, 3, 4, 1, 1'b0);
        run_job(3, 63, 1, 1, 1'b0);

        // Reset during WAIT_DONE of the third tile of a 2,2,2 job
        job_valid   = 1'b1;
        job_m_tiles = TDW'(2);
        job_n_tiles = TDW'(2);
        job_k_tiles = TDW'(2);
        tick;
        job_valid = 1'b0;
        tpu_done  = 1'b1;
        starts    = 0;
        for (int i = 0; i < 40 && starts < 3; i++) begin
            if (tpu_start) starts++;
            if (starts < 3) tick;
        end
        check_val("rst_reach_tile3", starts, 3);
        tpu_done = 1'b0;
        tick;
        check_val("rst_in_wait", busy, 1);
        srstn = 1'b0;
        tick;
        srstn = 1'b1;
        check_reset_outputs("midrst");
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (job_done || tpu_start) done_seen++;
        end
        check_val("midrst_quiet", done_seen, 0);
        run_job(1, 1, 1, 2, 1'b0);

`ifdef TILE_SCHED_TIMEOUT_EN
        // Watchdog: tpu_done withheld on the first tile of a 1,1,2 job
        job_valid   = 1'b1;
        job_m_tiles = TDW'(1);
        job_n_tiles = TDW'(1);
        job_k_tiles = TDW'(2);
        tick;
        job_valid = 1'b0;
        check_val("to_start", tpu_start, 1);
        repeat (TO) tick;
        check_val("to_not_yet", job_done, 0);
        tick;
        check_val("to_done", job_done, 1);
        check_val("to_err", job_err, 1);
        check_val("to_start_none", tpu_start, 0);
        tick;
        check_val("to_ready", job_ready, 1);
        check_val("to_start_after", tpu_start, 0);
        tick;
        check_val("to_start_after2", tpu_start, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
